// File: rtl/mult32_seq_ctrl.sv
// Unsigned 32x32 -> 64 multiplier built from four passes through one shared
// external 16x16 multiplier, with valid/ready handshakes on input and output.
module mult32_seq_ctrl #(
    parameter int unsigned MUL_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_p,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [31:0] mul_p,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        PP0,
        PP1,
        PP2,
        PP3,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] acc;
    logic        sub_cnt;
    logic        last_sub;
    logic        accept;
    logic        in_pass;
    logic [63:0] pp_shifted;

    // With a registered multiplier the product is only valid in the second
    // cycle a pass holds its operands.
    assign last_sub  = (sub_cnt == 1'(MUL_LAT));
    assign accept    = in_valid & in_ready;
    assign in_pass   = (state == PP0) || (state == PP1) ||
                       (state == PP2) || (state == PP3);
    assign out_valid = (state == DONE);
    assign out_p     = (state == DONE) ? acc : '0;
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, input ready, and operand selection for the shared multiplier.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        pp_shifted = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = PP0;
            end
            PP0: begin
                mul_a      = a_q[15:0];
                mul_b      = b_q[15:0];
                pp_shifted = 64'(mul_p);
                if (last_sub) state_nxt = PP1;
            end
            PP1: begin
                mul_a      = a_q[15:0];
                mul_b      = b_q[31:16];
                pp_shifted = 64'(mul_p) << 16;
                if (last_sub) state_nxt = PP2;
            end
            PP2: begin
                mul_a      = a_q[31:16];
                mul_b      = b_q[15:0];
                pp_shifted = 64'(mul_p) << 16;
                if (last_sub) state_nxt = PP3;
            end
            PP3: begin
                mul_a      = a_q[31:16];
                mul_b      = b_q[31:16];
                pp_shifted = 64'(mul_p) << 32;
                if (last_sub) state_nxt = DONE;
            end
            DONE: begin
                // Retiring and accepting on the same edge restarts straight into PP0.
                in_ready = out_ready;
                if (out_ready) state_nxt = in_valid ? PP0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, sub-cycle counting and partial-product accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            sub_cnt <= '0;
        end else if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            acc     <= '0;
            sub_cnt <= '0;
        end else if (in_pass) begin
            if (last_sub) begin
                acc     <= acc + pp_shifted;
                sub_cnt <= '0;
            end else begin
                sub_cnt <= sub_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// Bench for mult32_seq_ctrl: one instance with a combinational external
// multiplier (MUL_LAT=0) and one with a registered one (MUL_LAT=1).
module tb_mult32_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [2];
    logic        out_ready [2];
    logic [31:0] in_a      [2];
    logic [31:0] in_b      [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        busy      [2];
    logic [63:0] out_p     [2];
    logic [15:0] mul_a     [2];
    logic [15:0] mul_b     [2];
    logic [31:0] mp0;
    logic [31:0] mp1;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] e_mon;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External 16x16 multipliers: combinational and one-cycle registered.
    assign mp0 = 32'(mul_a[0]) * 32'(mul_b[0]);
    always @(posedge clk) mp1 <= 32'(mul_a[1]) * 32'(mul_b[1]);

    mult32_seq_ctrl #(.MUL_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_p(out_p[0]),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_p(mp0),
        .busy(busy[0])
    );

    mult32_seq_ctrl #(.MUL_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_p(out_p[1]),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_p(mp1),
        .busy(busy[1])
    );

    // Scoreboard: every output handshake pops the oldest expected product.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (out_valid[0] && out_ready[0]) begin
                vectors++;
                if (q0.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb0_unexpected: out_p=%h with no product pending", out_p[0]);
                end else begin
                    e_mon = q0.pop_front();
                    if (out_p[0] !== e_mon) begin
                        miscompares++;
                        $display("FAIL sb0_product: got %h expected %h", out_p[0], e_mon);
                    end
                end
            end
            if (out_valid[1] && out_ready[1]) begin
                vectors++;
                if (q1.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb1_unexpected: out_p=%h with no product pending", out_p[1]);
                end else begin
                    e_mon = q1.pop_front();
                    if (out_p[1] !== e_mon) begin
                        miscompares++;
                        $display("FAIL sb1_product: got %h expected %h", out_p[1], e_mon);
                    end
                end
            end
        end
    end

    task automatic push_exp(input int d, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] v;
        v = 64'(a) * 64'(b);
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    // Presents operands from a negedge, waits for acceptance, then scrambles
    // the inputs; returns at the negedge right after the accept edge.
    task automatic accept(input int d, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        in_a[d] = a;
        in_b[d] = b;
        in_valid[d] = 1'b1;
        #1;
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[d]) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: dut%0d in_ready=%b expected 1", d, in_ready[d]);
            in_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        push_exp(d, a, b);
        #1;
        in_valid[d] = 1'b0;
        in_a[d] = ~a;
        in_b[d] = ~b;
        @(negedge clk);
    endtask

    // Counts accept-relative edges until out_valid (bounded).
    task automatic wait_valid(input int d, output int n);
        n = 0;
        while (!out_valid[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b1;
            in_a[d] = '0;
            in_b[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_p[d] !== 64'h0 ||
                mul_a[d] !== 16'h0 || mul_b[d] !== 16'h0 || busy[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_values: dut%0d rdy=%b vld=%b p=%h ma=%h mb=%h busy=%b expected 1 0 0 0 0 0",
                         d, in_ready[d], out_valid[d], out_p[d], mul_a[d], mul_b[d], busy[d]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_max_operands();
        accept(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (mul_a[0] !== 16'hFFFF || mul_b[0] !== 16'hFFFF || out_valid[0] !== 1'b0 || busy[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL max_pass%0d: ma=%h mb=%h vld=%b busy=%b expected ffff ffff 0 1",
                         k, mul_a[0], mul_b[0], out_valid[0], busy[0]);
            end
            @(negedge clk);
        end
        vectors++;
        if (out_valid[0] !== 1'b1 || out_p[0] !== 64'hFFFFFFFE00000001 || mul_a[0] !== 16'h0 || mul_b[0] !== 16'h0) begin
            miscompares++;
            $display("FAIL max_done: vld=%b p=%h ma=%h mb=%h expected 1 fffffffe00000001 0 0",
                     out_valid[0], out_p[0], mul_a[0], mul_b[0]);
        end
        @(negedge clk);
        vectors++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL max_retire: vld=%b busy=%b expected 0 0", out_valid[0], busy[0]);
        end
    endtask

    task automatic test_shifts();
        logic [31:0] ta[2];
        logic [31:0] tbv[2];
        logic [63:0] tp[2];
        int n;
        ta[0] = 32'h0000FFFF; tbv[0] = 32'hFFFF0000; tp[0] = 64'h0000FFFE00010000;
        ta[1] = 32'h00010000; tbv[1] = 32'h00010000; tp[1] = 64'h0000000100000000;
        for (int i = 0; i < 2; i++) begin
            accept(0, ta[i], tbv[i]);
            wait_valid(0, n);
            vectors++;
            if (n != 4 || out_p[0] !== tp[i]) begin
                miscompares++;
                $display("FAIL shift%0d: latency=%0d p=%h expected 4 %h", i, n, out_p[0], tp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] e;
        int n;
        e = 64'(32'hDEADBEEF) * 64'(32'h01234567);
        out_ready[0] = 1'b0;
        accept(0, 32'hDEADBEEF, 32'h01234567);
        wait_valid(0, n);
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d expected 4", n);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid[0] !== 1'b1 || out_p[0] !== e || in_ready[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: vld=%b p=%h rdy=%b expected 1 %h 0", i, out_valid[0], out_p[0], in_ready[0], e);
            end
            @(negedge clk);
        end
        in_a[0] = 32'd3;
        in_b[0] = 32'd5;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        #1;
        vectors++;
        if (in_ready[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_done_ready: rdy=%b expected 1", in_ready[0]);
        end
        @(posedge clk);
        push_exp(0, 32'd3, 32'd5);
        #1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b1 || mul_a[0] !== 16'd3 || mul_b[0] !== 16'd5) begin
            miscompares++;
            $display("FAIL bp_restart: vld=%b busy=%b ma=%h mb=%h expected 0 1 0003 0005",
                     out_valid[0], busy[0], mul_a[0], mul_b[0]);
        end
        wait_valid(0, n);
        vectors++;
        if (n != 4 || out_p[0] !== 64'd15) begin
            miscompares++;
            $display("FAIL bp_second: latency=%0d p=%h expected 4 000000000000000f", n, out_p[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        accept(0, 32'h12345678, 32'h00000002);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (mul_a[0] !== 16'h1234 || mul_b[0] !== 16'h0002) begin
            miscompares++;
            $display("FAIL rstmid_pp2: ma=%h mb=%h expected 1234 0002", mul_a[0], mul_b[0]);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        @(negedge clk);
        vectors++;
        if (out_valid[0] !== 1'b0 || out_p[0] !== 64'h0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1 ||
            mul_a[0] !== 16'h0 || mul_b[0] !== 16'h0) begin
            miscompares++;
            $display("FAIL rstmid_state: vld=%b p=%h busy=%b rdy=%b ma=%h mb=%h expected 0 0 0 1 0 0",
                     out_valid[0], out_p[0], busy[0], in_ready[0], mul_a[0], mul_b[0]);
        end
        accept(0, 32'd7, 32'd6);
        wait_valid(0, n);
        vectors++;
        if (n != 4 || out_p[0] !== 64'd42) begin
            miscompares++;
            $display("FAIL rstmid_after: latency=%0d p=%h expected 4 000000000000002a", n, out_p[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int n;
        logic [63:0] e;
        e = 64'(32'h00C0FFEE) * 64'(32'h0BADF00D);
        accept(0, 32'h00C0FFEE, 32'h0BADF00D);
        @(negedge clk);
        in_a[0] = 32'hFFFFFFFF;
        in_b[0] = 32'hFFFFFFFF;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_ignore%0d: rdy=%b busy=%b expected 0 1", i, in_ready[0], busy[0]);
            end
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        wait_valid(0, n);
        vectors++;
        if (n != 1 || out_p[0] !== e) begin
            miscompares++;
            $display("FAIL busy_product: wait=%0d p=%h expected 1 %h", n, out_p[0], e);
        end
        @(negedge clk);
        vectors++;
        if (busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_idle: busy=%b expected 0", busy[0]);
        end
    endtask

    task automatic test_lat1();
        logic [15:0] ea[4];
        logic [15:0] eb[4];
        ea[0] = 16'h3; eb[0] = 16'h5;
        ea[1] = 16'h3; eb[1] = 16'h4;
        ea[2] = 16'h2; eb[2] = 16'h5;
        ea[3] = 16'h2; eb[3] = 16'h4;
        out_ready[1] = 1'b1;
        accept(1, 32'h00020003, 32'h00040005);
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (mul_a[1] !== ea[k/2] || mul_b[1] !== eb[k/2] || out_valid[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL lat1_cycle%0d: ma=%h mb=%h vld=%b expected %h %h 0",
                         k, mul_a[1], mul_b[1], out_valid[1], ea[k/2], eb[k/2]);
            end
            @(negedge clk);
        end
        vectors++;
        if (out_valid[1] !== 1'b1 || out_p[1] !== 64'h000000080016000F) begin
            miscompares++;
            $display("FAIL lat1_done: vld=%b p=%h expected 1 000000080016000f", out_valid[1], out_p[1]);
        end
        @(negedge clk);
        vectors++;
        if (busy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL lat1_idle: busy=%b expected 0", busy[1]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int t;
        int t_prev = 0;
        logic [31:0] a;
        logic [31:0] b;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            in_a[0] = a;
            in_b[0] = b;
            in_valid[0] = 1'b1;
            n = 0;
            #1;
            while (!in_ready[0] && n < 50) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            push_exp(0, a, b);
            #1;
            t = cyc;
            if (i > 0) begin
                vectors++;
                if (t - t_prev != 5) begin
                    miscompares++;
                    $display("FAIL b2b_interval%0d: got %0d cycles expected 5", i, t - t_prev);
                end
            end
            t_prev = t;
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        n = 0;
        while (busy[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_max_operands();
        test_shifts();
        test_backpressure();
        test_reset_mid();
        test_busy_ignore();
        test_lat1();
        test_back_to_back();
        repeat (3) @(negedge clk);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: pending dut0=%0d dut1=%0d expected 0 0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult32_seq_ctrl.md
Name: mult32_seq_ctrl

Overview:
- Sequencing controller that computes an unsigned 32x32 -> 64-bit product by time-multiplexing one external 16x16 vedic multiplier over four partial-product passes.
- Used in NTT butterfly/twiddle paths where area outweighs throughput.
- Wraps the shared multiplier with a valid/ready handshake on both input and output, so it drops into the existing streaming datapath.

Parameters:
- MUL_LAT, 0, latency of the external 16x16 multiplier in cycles. 0 = combinational (mul_p valid in the same cycle as mul_a/mul_b); 1 = registered. No other values are legal.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept operands
- in_a  in  32  multiplicand, unsigned
- in_b  in  32  multiplier, unsigned
- out_valid  out  1  product valid
- out_ready  in  1  downstream accepts product
- out_p  out  64  product in_a*in_b
- mul_a  out  16  operand A to the external 16x16 multiplier
- mul_b  out  16  operand B to the external 16x16 multiplier
- mul_p  in  32  product returned by the external multiplier
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous, active-high, and applies in the same edge. Reset values:
  - in_ready = 1
  - out_valid = 0, out_p = 0
  - mul_a = 0, mul_b = 0
  - busy = 0
  - accumulator = 0, state = IDLE
- States: IDLE, PP0, PP1, PP2, PP3, DONE.
- Pass order and operand drive:
  - PP0: mul_a = a[15:0], mul_b = b[15:0]
  - PP1: mul_a = a[15:0], mul_b = b[31:16]
  - PP2: mul_a = a[31:16], mul_b = b[15:0]
  - PP3: mul_a = a[31:16], mul_b = b[31:16]
- mul_a and mul_b are 0 in IDLE and DONE.
- Accept:
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - On in_valid & in_ready, operands are latched into internal registers, the accumulator is cleared, and state goes to PP0.
- Each PPk state is held for MUL_LAT+1 cycles, tracked by a sub-cycle counter.
- On the last cycle of PPk, mul_p is added to the 64-bit accumulator:
  - PP0: shift 0
  - PP1 and PP2: shift 16
  - PP3: shift 32
- Accumulation uses a zero-extended 64-bit add. The sum cannot overflow 64 bits, so no carry out is kept.
- After PP3 the state goes to DONE with out_valid = 1 and out_p = accumulator.
- Latency from the accept edge to out_valid high is 4*(MUL_LAT+1) cycles:
  - MUL_LAT=0: 4 cycles
  - MUL_LAT=1: 8 cycles
- Output handshake:
  - out_p and out_valid stay stable while out_valid & !out_ready.
  - On out_valid & out_ready, out_valid drops next cycle and state goes to IDLE, unless a new operand is accepted on the same edge.
- Simultaneous out handshake and in handshake in DONE: the product is retired and the new operands are latched in that same edge, with state going to PP0. Back-to-back throughput is one product per 4*(MUL_LAT+1)+1 cycles.
- in_a/in_b may change after acceptance without effect, because they are latched.
- in_valid while busy and not in DONE is ignored (in_ready=0). The operands are not captured.
- rst asserted mid-operation: the in-flight product is discarded and all outputs return to their reset values on that edge.
- No wrap or saturation anywhere; all arithmetic is unsigned.

Test Plan:
- MUL_LAT=0, in_a=0xFFFFFFFF, in_b=0xFFFFFFFF, out_ready=1 -> out_valid high 4 cycles after accept, out_p=0xFFFFFFFE00000001; mul_a/mul_b sequence FFFF/FFFF four times.
- in_a=0x0000FFFF, in_b=0xFFFF0000 -> out_p=0x0000FFFE00010000. in_a=0x00010000, in_b=0x00010000 -> out_p=0x0000000100000000. Confirms the shift placement of PP1/PP2/PP3.
- out_ready held 0 for 3 cycles after out_valid -> out_p/out_valid stable and in_ready=0. Then present a new pair (3, 5) with out_ready=1 on the same edge -> first product retired, second accepted that edge, out_p=15 after 4 more cycles.
- rst pulsed during PP2 of 0x12345678*0x2 -> next cycle state IDLE, out_valid=0, out_p=0, busy=0. A following 7*6 operation yields out_p=42.
- MUL_LAT=1, in_a=0x00020003, in_b=0x00040005 -> each mul_a/mul_b pair held 2 cycles, out_valid 8 cycles after accept, out_p=0x000000080016000F.
- in_valid asserted with new operands while busy in PP1 -> not accepted, in_ready=0, the original product is unaffected.
